prog_counter: RTL and testbench

Parametrised successor to the 4-bit enable/reset first_counter. Adds:
- configurable width and modulus
- up/down counting
- synchronous parallel load
- prescaler
- wrap, saturate and one-shot modes
- terminal-count pulse and sticky overflow flag

Used as a general event/interval counter. With WIDTH=4, MAX_VAL=15, PRESCALE=1, mode=wrap, up_dn=1 it is cycle-identical to first_counter.

---
 rtl/prog_counter_pkg.sv | 20 ++
 rtl/prog_counter_prescaler.sv | 38 +++
 rtl/prog_counter.sv | 146 ++++++++++++++
 tb/tb_prog_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
// Shared types for the programmable counter: counting-mode encoding and
// one-shot FSM state encoding.
package prog_counter_pkg;

  // Mode encoding on the 2-bit mode input. 2'b11 is reserved and treated as wrap.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_t;

  // One-shot FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/prog_counter_prescaler.sv
// prog_counter_prescaler
// Divides enabled cycles by PRESCALE. The step output is high in the cycle
// where enable is high and the internal count has reached PRESCALE-1.
// The count holds while enable is low.
//
// Ports:
//   clk    in   clock, posedge
//   reset  in   synchronous, active-high
//   enable in   count enable
//   clear  in   synchronous clear of the internal count
//   step   out  one-cycle step strobe (combinational from psc and enable)
module prog_counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  assign step = enable && (psc == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      psc <= '0;
    end else if (enable) begin
      if (psc == LAST) psc <= '0;
      else             psc <= psc + 1'b1;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter
// Parametrised up/down event counter with prescaler, parallel load, and
// wrap / saturate / one-shot terminal behaviour. tc is a registered
// one-cycle pulse coincident with the wrapped/held count; ovf is sticky.
//
// Optional build macro PROG_COUNTER_CAPTURE_EN adds a capture strobe that
// snapshots the pre-edge count into capture_out.
//
// Ports:
//   clk         in   clock, posedge
//   reset       in   synchronous, active-high
//   enable      in   count enable (qualifies prescaler)
//   up_dn       in   1 = up, 0 = down
//   mode        in   00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   load        in   parallel load strobe
//   load_val    in   load value (clamped to MAX_VAL)
//   start       in   one-shot arm strobe
//   ovf_clr     in   clears ovf (set wins)
//   count_out   out  current count
//   tc          out  terminal-count pulse
//   busy        out  one-shot running
//   ovf         out  sticky overflow/underflow
//   capture     in   (PROG_COUNTER_CAPTURE_EN) capture strobe
//   capture_out out  (PROG_COUNTER_CAPTURE_EN) captured count
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             busy,
  output logic             ovf
`ifdef PROG_COUNTER_CAPTURE_EN
  ,
  input  logic             capture,
  output logic [WIDTH-1:0] capture_out
`endif
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_set;
  logic             psc_clr;
  logic             step;
  logic             at_term;
  logic             oneshot;

  prog_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (psc_clr),
    .step   (step)
  );

  assign oneshot = (mode == MODE_ONESHOT);
  assign at_term = up_dn ? (count_out == MAXV) : (count_out == '0);
  assign busy    = (state == RUN);

  always_comb begin
    count_nxt = count_out;
    tc_nxt    = 1'b0;
    ovf_set   = 1'b0;
    psc_clr   = load;
    state_nxt = oneshot ? state : IDLE;

    if (load) begin
      count_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (oneshot && start && (state != RUN)) begin
      // Arm: preload the start value and restart the prescaler phase.
      count_nxt = up_dn ? '0 : MAXV;
      psc_clr   = 1'b1;
      state_nxt = RUN;
    end else if (step) begin
      case (mode)
        MODE_ONESHOT: begin
          if (state == RUN) begin
            if (at_term) begin
              tc_nxt    = 1'b1;
              state_nxt = DONE;
            end else begin
              count_nxt = up_dn ? count_out + 1'b1 : count_out - 1'b1;
            end
          end
        end
        MODE_SAT: begin
          if (at_term) begin
            tc_nxt  = 1'b1;
            ovf_set = 1'b1;
          end else begin
            count_nxt = up_dn ? count_out + 1'b1 : count_out - 1'b1;
          end
        end
        default: begin
          if (at_term) begin
            count_nxt = up_dn ? '0 : MAXV;
            tc_nxt    = 1'b1;
            ovf_set   = 1'b1;
          end else begin
            count_nxt = up_dn ? count_out + 1'b1 : count_out - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count_out <= '0;
      tc        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_out <= count_nxt;
      tc        <= tc_nxt;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef PROG_COUNTER_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset)        capture_out <= '0;
    else if (capture) capture_out <= count_out;
  end
`endif

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_dn = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       capture = 1'b0;

  logic [3:0] c0, c1, c2;
  logic       tc0, tc1, tc2;
  logic       b0, b1, b2;
  logic       o0, o1, o2;
`ifdef PROG_COUNTER_CAPTURE_EN
  logic [3:0] cap0, cap1, cap2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: first_counter-compatible; u1: modulus 10, prescale 3; u2: modulus 10.
  prog_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .start(start), .ovf_clr(ovf_clr),
    .count_out(c0), .tc(tc0), .busy(b0), .ovf(o0)
`ifdef PROG_COUNTER_CAPTURE_EN
    , .capture(capture), .capture_out(cap0)
`endif
  );

  prog_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .start(start), .ovf_clr(ovf_clr),
    .count_out(c1), .tc(tc1), .busy(b1), .ovf(o1)
`ifdef PROG_COUNTER_CAPTURE_EN
    , .capture(capture), .capture_out(cap1)
`endif
  );

  prog_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .mode(mode),
    .load(load), .load_val(load_val), .start(start), .ovf_clr(ovf_clr),
    .count_out(c2), .tc(tc2), .busy(b2), .ovf(o2)
`ifdef PROG_COUNTER_CAPTURE_EN
    , .capture(capture), .capture_out(cap2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- reset state ----
    tick(); tick();
    chk("rst_count", 32'(c0), 0);
    chk("rst_tc",    32'(tc0), 0);
    chk("rst_busy",  32'(b0), 0);
    chk("rst_ovf",   32'(o0), 0);

    // ---- u0: wrap up, 20 enabled cycles ----
    reset = 1'b0; mode = 2'b00; up_dn = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("wrap_count_%0d", i), 32'(c0), i % 16);
      chk($sformatf("wrap_tc_%0d", i),    32'(tc0), (i == 16) ? 1 : 0);
      chk($sformatf("wrap_ovf_%0d", i),   32'(o0), (i >= 16) ? 1 : 0);
    end

    // ---- u1: prescale 3, down, wrap, load 2 ----
    reset = 1'b1; enable = 1'b0; tick();
    reset = 1'b0; up_dn = 1'b0; load = 1'b1; load_val = 4'd2; tick();
    chk("psc_load", 32'(c1), 2);
    load = 1'b0; enable = 1'b1;
    tick(); chk("psc_a1", 32'(c1), 2);
    tick(); chk("psc_a2", 32'(c1), 2);
    tick(); chk("psc_a3", 32'(c1), 1);
    tick(); chk("psc_b1", 32'(c1), 1);
    tick(); chk("psc_b2", 32'(c1), 1);
    enable = 1'b0;
    tick(); chk("psc_hold1", 32'(c1), 1);
    tick(); chk("psc_hold2", 32'(c1), 1);
    enable = 1'b1;
    tick(); chk("psc_b3", 32'(c1), 0);
    tick(); tick(); chk("psc_c2", 32'(c1), 0);
    chk("psc_c2_tc", 32'(tc1), 0);
    tick();
    chk("psc_wrap", 32'(c1), 9);
    chk("psc_wrap_tc", 32'(tc1), 1);
    chk("psc_wrap_ovf", 32'(o1), 1);
    tick(); chk("psc_tc_low", 32'(tc1), 0);

    // ---- u2: saturate up ----
    reset = 1'b1; enable = 1'b0; tick();
    reset = 1'b0; mode = 2'b01; up_dn = 1'b1; load = 1'b1; load_val = 4'd8; tick();
    chk("sat_load", 32'(c2), 8);
    load = 1'b0; enable = 1'b1;
    tick(); chk("sat_1", 32'(c2), 9); chk("sat_1_tc", 32'(tc2), 0); chk("sat_1_ovf", 32'(o2), 0);
    tick(); chk("sat_2", 32'(c2), 9); chk("sat_2_tc", 32'(tc2), 1); chk("sat_2_ovf", 32'(o2), 1);
    tick(); chk("sat_3", 32'(c2), 9); chk("sat_3_tc", 32'(tc2), 1);
    ovf_clr = 1'b1;
    tick(); chk("sat_4", 32'(c2), 9); chk("sat_4_tc", 32'(tc2), 1);
    chk("sat_ovf_set_wins", 32'(o2), 1);
    enable = 1'b0;
    tick(); chk("sat_ovf_clr", 32'(o2), 0); chk("sat_tc_low", 32'(tc2), 0);
    ovf_clr = 1'b0;

    // ---- u2: one-shot up ----
    reset = 1'b1; tick();
    reset = 1'b0; mode = 2'b10; up_dn = 1'b1; enable = 1'b1;
    tick(); chk("os_idle_count", 32'(c2), 0); chk("os_idle_busy", 32'(b2), 0);
    start = 1'b1;
    tick(); chk("os_start_count", 32'(c2), 0); chk("os_start_busy", 32'(b2), 1);
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("os_run_%0d", i), 32'(c2), i);
      chk($sformatf("os_run_busy_%0d", i), 32'(b2), 1);
      chk($sformatf("os_run_tc_%0d", i), 32'(tc2), 0);
    end
    tick();
    chk("os_done_count", 32'(c2), 9);
    chk("os_done_tc", 32'(tc2), 1);
    chk("os_done_busy", 32'(b2), 0);
    chk("os_done_ovf", 32'(o2), 0);
    tick(); chk("os_hold_count", 32'(c2), 9); chk("os_hold_tc", 32'(tc2), 0);
    tick(); chk("os_hold2_count", 32'(c2), 9);
    start = 1'b1;
    tick(); chk("os_restart_count", 32'(c2), 0); chk("os_restart_busy", 32'(b2), 1);
    start = 1'b0;
    tick(); chk("os_rerun_count", 32'(c2), 1);

    // ---- reset mid-RUN ----
    reset = 1'b1;
    tick();
    chk("rst_run_count", 32'(c2), 0);
    chk("rst_run_busy", 32'(b2), 0);
    chk("rst_run_tc", 32'(tc2), 0);
    reset = 1'b0;
    tick(); chk("rst_run_idle", 32'(c2), 0); chk("rst_run_idle_busy", 32'(b2), 0);

    // ---- load clamp ----
    mode = 2'b00; enable = 1'b0; load = 1'b1; load_val = 4'd13;
    tick();
    chk("load_clamp_m9", 32'(c2), 9);
    chk("load_noclamp_m15", 32'(c0), 13);
    chk("load_tc", 32'(tc2), 0);
    load = 1'b0;

`ifdef PROG_COUNTER_CAPTURE_EN
    // ---- capture while counting ----
    load = 1'b1; load_val = 4'd3; tick();
    load = 1'b0; enable = 1'b1;
    tick(); tick();
    chk("cap_pre", 32'(c2), 5);
    capture = 1'b1;
    tick();
    chk("cap_count", 32'(c2), 6);
    chk("cap_value", 32'(cap2), 5);
    capture = 1'b0;
    tick(); chk("cap_hold", 32'(cap2), 5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
